// File: rtl/clock_pkg.sv
// Shared types and widths for the clock mode controller and its alarm ringer.
// Latency: none. This file holds only declarations.
// Backpressure: none. This file holds only declarations.
package clock_pkg;

    typedef enum logic [1:0] {
        NORMAL     = 2'b00,
        ALARM_SET  = 2'b01,
        STOP_WATCH = 2'b11,
        SET_TIME   = 2'b10
    } mode_t;

    localparam int HOURS_W   = 5;
    localparam int MINUTES_W = 6;
    localparam int DISP_W    = 6;

    // Registered button levels and their rising edges, one bit per button.
    typedef struct packed {
        logic mode;
        logic inc;
        logic snooze;
    } btn_t;

    // Width of an alarm channel index. A single channel still gets one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alarm_ringer.sv
// Alarm channels: match-edge detection, lowest-index ring select, shared snooze timer and ring timeout.
// Latency: ringing is registered, so it shows one cycle after a match edge, snooze expiry or dismiss edge.
// Backpressure: none. A request that arrives while a channel is ringing is dropped, not queued.
module alarm_ringer
    import clock_pkg::*;
#(
    parameter int NUM_ALARMS = 2,
    parameter int SNOOZE_SEC = 300,
    parameter int RING_SEC   = 60
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sec_tick,
    input  logic                            dismiss_edge,
    input  logic                            snooze_edge,
    input  logic [HOURS_W-1:0]              normal_hours,
    input  logic [MINUTES_W-1:0]            normal_minutes,
    input  logic [HOURS_W*NUM_ALARMS-1:0]   alarm_hours,
    input  logic [MINUTES_W*NUM_ALARMS-1:0] alarm_minutes,
    input  logic [NUM_ALARMS-1:0]           alarm_on,
    output logic [NUM_ALARMS-1:0]           alarm_ringing,
    output logic                            alarm_sound
);

    localparam int SEL_W  = sel_width(NUM_ALARMS);
    localparam int SNZ_W  = $clog2(SNOOZE_SEC + 1);
    localparam int RING_W = $clog2(RING_SEC + 1);

    logic [NUM_ALARMS-1:0] match, match_q, match_rise;
    logic [NUM_ALARMS-1:0] req, grant, snz_vec, ringing_n;
    logic [RING_W-1:0]     ring_cnt_q, ring_cnt_n;
    logic                  snz_armed_q, snz_armed_n;
    logic [SEL_W-1:0]      snz_ch_q, snz_ch_n, ring_idx;
    logic [SNZ_W-1:0]      snz_cnt_q, snz_cnt_n;
    logic                  snz_fire;
    logic                  found;

    // Per-channel comparison of the enabled alarm time against current time.
    always_comb begin
        match = '0;
        for (int k = 0; k < NUM_ALARMS; k++) begin
            match[k] = alarm_on[k]
                    && (alarm_hours[k*HOURS_W +: HOURS_W] == normal_hours)
                    && (alarm_minutes[k*MINUTES_W +: MINUTES_W] == normal_minutes);
        end
    end

    // Only the first cycle of a match starts ringing, so a dismissed alarm stays quiet for the rest of the minute.
    assign match_rise  = match & ~match_q;
    assign alarm_sound = |alarm_ringing;

    // Next ringing, ring timer and snooze state.
    always_comb begin
        ringing_n   = alarm_ringing;
        ring_cnt_n  = ring_cnt_q;
        snz_armed_n = snz_armed_q;
        snz_ch_n    = snz_ch_q;
        snz_cnt_n   = snz_cnt_q;
        snz_fire    = 1'b0;
        snz_vec     = '0;
        grant       = '0;
        found       = 1'b0;
        ring_idx    = '0;

        for (int k = 0; k < NUM_ALARMS; k++) begin
            if (alarm_ringing[k]) begin
                ring_idx = SEL_W'(k);
            end
        end

        // The snooze is consumed when it expires, whether or not it wins the ring.
        if (snz_armed_q && sec_tick) begin
            if (snz_cnt_q == SNZ_W'(1)) begin
                snz_fire    = 1'b1;
                snz_armed_n = 1'b0;
            end else begin
                snz_cnt_n = snz_cnt_q - 1'b1;
            end
        end
        snz_vec[snz_ch_q] = snz_fire;
        req = match_rise | (snz_vec & alarm_on);

        if (|alarm_ringing) begin
            if (sec_tick) begin
                if (ring_cnt_q == RING_W'(RING_SEC - 1)) begin
                    ringing_n = '0;
                end else begin
                    ring_cnt_n = ring_cnt_q + 1'b1;
                end
            end
            // A snooze outranks a dismiss or the ring timeout in the same cycle.
            if (snooze_edge) begin
                ringing_n   = '0;
                snz_armed_n = 1'b1;
                snz_ch_n    = ring_idx;
                snz_cnt_n   = SNZ_W'(SNOOZE_SEC);
            end else if (dismiss_edge) begin
                ringing_n = '0;
            end
        end else begin
            for (int k = 0; k < NUM_ALARMS; k++) begin
                if (req[k] && !found) begin
                    grant[k] = 1'b1;
                    found    = 1'b1;
                end
            end
            ringing_n  = grant;
            ring_cnt_n = '0;
        end

        // A channel switched off loses its ring and any pending snooze at once.
        ringing_n = ringing_n & alarm_on;
        if (snz_armed_n && !alarm_on[snz_ch_n]) begin
            snz_armed_n = 1'b0;
        end
        if (ringing_n == '0) begin
            ring_cnt_n = '0;
        end
    end

    // Ringer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q       <= '0;
            alarm_ringing <= '0;
            ring_cnt_q    <= '0;
            snz_armed_q   <= 1'b0;
            snz_ch_q      <= '0;
            snz_cnt_q     <= '0;
        end else begin
            match_q       <= match;
            alarm_ringing <= ringing_n;
            ring_cnt_q    <= ring_cnt_n;
            snz_armed_q   <= snz_armed_n;
            snz_ch_q      <= snz_ch_n;
            snz_cnt_q     <= snz_cnt_n;
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Clock mode sequencer with idle auto-return, display mux, and the alarm ringer instance.
// Latency: button edges act one cycle after the level rises; state is registered; enables, normal_en and display are combinational.
// Backpressure: none. A mode edge is simply ignored until the current mode's ack flag is high.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int NUM_ALARMS = 2,
    parameter int SNOOZE_SEC = 300,
    parameter int RING_SEC   = 60,
    parameter int IDLE_SEC   = 30
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               sec_tick,
    input  logic                               mode_button,
    input  logic                               inc_button,
    input  logic                               snooze_button,
    input  logic [HOURS_W-1:0]                 normal_hours,
    input  logic [MINUTES_W-1:0]               normal_minutes,
    input  logic [HOURS_W*NUM_ALARMS-1:0]      alarm_hours,
    input  logic [MINUTES_W*NUM_ALARMS-1:0]    alarm_minutes,
    input  logic [NUM_ALARMS-1:0]              alarm_on,
    input  logic                               set_alarm_ack_flag,
    input  logic                               stop_watch_ack_flag,
    input  logic                               set_time_ack_flag,
    input  logic [HOURS_W-1:0]                 set_time_hours,
    input  logic [MINUTES_W-1:0]               set_time_minutes,
    input  logic [MINUTES_W-1:0]               stop_watch_minutes,
    input  logic [MINUTES_W-1:0]               stop_watch_seconds,
    output logic                               set_time_en,
    output logic                               set_alarm_en,
    output logic [sel_width(NUM_ALARMS)-1:0]   alarm_sel,
    output logic                               stop_watch_en,
    output logic                               normal_en,
    output logic                               alarm_sound,
    output logic [NUM_ALARMS-1:0]              alarm_ringing,
    output logic [DISP_W-1:0]                  hours_fsm,
    output logic [DISP_W-1:0]                  minutes_fsm
);

    localparam int SEL_W  = sel_width(NUM_ALARMS);
    localparam int IDLE_W = $clog2(IDLE_SEC + 1);

    btn_t             btn_lvl_q, btn_prev_q, btn_edge;
    logic             any_edge;
    mode_t            state_q, state_n;
    logic [SEL_W-1:0] sel_q, sel_n;
    logic [IDLE_W-1:0] idle_q, idle_n;
    logic             idle_timeout;

    // Register each button once, then keep the previous level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_lvl_q  <= '0;
            btn_prev_q <= '0;
        end else begin
            btn_lvl_q  <= {mode_button, inc_button, snooze_button};
            btn_prev_q <= btn_lvl_q;
        end
    end

    assign btn_edge = btn_lvl_q & ~btn_prev_q;
    assign any_edge = btn_edge.mode | btn_edge.inc | btn_edge.snooze;

    // The second that would complete the idle period forces NORMAL, even over a same-cycle mode edge.
    assign idle_timeout = (state_q != NORMAL) && sec_tick
                       && (idle_q == IDLE_W'(IDLE_SEC - 1));

    // Mode state, selected alarm channel and idle counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= NORMAL;
            sel_q   <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_n;
            sel_q   <= sel_n;
            idle_q  <= idle_n;
        end
    end

    // Next mode, channel select, idle count and the timekeeper load strobe.
    always_comb begin
        state_n   = state_q;
        sel_n     = sel_q;
        idle_n    = idle_q;
        normal_en = 1'b0;

        if (any_edge) begin
            idle_n = '0;
        end else if (sec_tick) begin
            idle_n = idle_q + 1'b1;
        end

        case (state_q)
            NORMAL: begin
                idle_n = '0;
                if (btn_edge.mode) begin
                    state_n = ALARM_SET;
                    sel_n   = '0;
                end
            end
            ALARM_SET: begin
                if (btn_edge.mode && set_alarm_ack_flag) begin
                    if (int'(sel_q) < NUM_ALARMS - 1) begin
                        sel_n = sel_q + 1'b1;
                    end else begin
                        state_n = STOP_WATCH;
                        sel_n   = '0;
                    end
                end
            end
            STOP_WATCH: begin
                if (btn_edge.mode && stop_watch_ack_flag) begin
                    state_n = SET_TIME;
                end
            end
            SET_TIME: begin
                if (btn_edge.mode && set_time_ack_flag) begin
                    state_n   = NORMAL;
                    normal_en = 1'b1;
                end
            end
            default: state_n = NORMAL;
        endcase

        // An abandoned edit returns home without loading the timekeeper.
        if (idle_timeout) begin
            state_n   = NORMAL;
            sel_n     = '0;
            idle_n    = '0;
            normal_en = 1'b0;
        end
    end

    assign set_time_en   = (state_q == SET_TIME);
    assign set_alarm_en  = (state_q == ALARM_SET);
    assign stop_watch_en = (state_q == STOP_WATCH);
    assign alarm_sel     = sel_q;

    // Display source follows the current mode; normal time is the fallback.
    always_comb begin
        hours_fsm   = DISP_W'(normal_hours);
        minutes_fsm = DISP_W'(normal_minutes);
        case (state_q)
            ALARM_SET: begin
                hours_fsm   = DISP_W'(alarm_hours[int'(sel_q)*HOURS_W +: HOURS_W]);
                minutes_fsm = DISP_W'(alarm_minutes[int'(sel_q)*MINUTES_W +: MINUTES_W]);
            end
            STOP_WATCH: begin
                hours_fsm   = DISP_W'(stop_watch_minutes);
                minutes_fsm = DISP_W'(stop_watch_seconds);
            end
            SET_TIME: begin
                hours_fsm   = DISP_W'(set_time_hours);
                minutes_fsm = DISP_W'(set_time_minutes);
            end
            default: ;
        endcase
    end

    alarm_ringer #(
        .NUM_ALARMS (NUM_ALARMS),
        .SNOOZE_SEC (SNOOZE_SEC),
        .RING_SEC   (RING_SEC)
    ) u_ringer (
        .clk            (clk),
        .rst            (rst),
        .sec_tick       (sec_tick),
        .dismiss_edge   (btn_edge.inc | btn_edge.mode),
        .snooze_edge    (btn_edge.snooze),
        .normal_hours   (normal_hours),
        .normal_minutes (normal_minutes),
        .alarm_hours    (alarm_hours),
        .alarm_minutes  (alarm_minutes),
        .alarm_on       (alarm_on),
        .alarm_ringing  (alarm_ringing),
        .alarm_sound    (alarm_sound)
    );

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed vectors push expected outputs to a scoreboard queue.
// Latency: a monitor compares each queued expectation at the following falling clock edge.
// Backpressure: none. The stimulus waits for each comparison before it moves on.
module tb_clock_mode_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sec_tick, mode_button, inc_button, snooze_button;
    logic [4:0]  normal_hours;
    logic [5:0]  normal_minutes;
    logic [9:0]  alarm_hours;
    logic [11:0] alarm_minutes;
    logic [1:0]  alarm_on;
    logic        set_alarm_ack_flag, stop_watch_ack_flag, set_time_ack_flag;
    logic [4:0]  set_time_hours;
    logic [5:0]  set_time_minutes, stop_watch_minutes, stop_watch_seconds;
    logic        set_time_en, set_alarm_en, stop_watch_en, normal_en, alarm_sound;
    logic [0:0]  alarm_sel;
    logic [1:0]  alarm_ringing;
    logic [5:0]  hours_fsm, minutes_fsm;

    typedef struct packed {
        logic       ste;
        logic       sae;
        logic [0:0] sel;
        logic       swe;
        logic       ne;
        logic       snd;
        logic [1:0] ring;
        logic [5:0] hrs;
        logic [5:0] mins;
    } obs_t;

    obs_t  cur;
    obs_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;

    // Bench-local mode codes: 0 normal, 1 alarm set, 2 stopwatch, 3 set time.
    localparam int M_N = 0, M_A = 1, M_W = 2, M_T = 3;

    clock_mode_ctrl #(
        .NUM_ALARMS (2),
        .SNOOZE_SEC (3),
        .RING_SEC   (60),
        .IDLE_SEC   (30)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .sec_tick            (sec_tick),
        .mode_button         (mode_button),
        .inc_button          (inc_button),
        .snooze_button       (snooze_button),
        .normal_hours        (normal_hours),
        .normal_minutes      (normal_minutes),
        .alarm_hours         (alarm_hours),
        .alarm_minutes       (alarm_minutes),
        .alarm_on            (alarm_on),
        .set_alarm_ack_flag  (set_alarm_ack_flag),
        .stop_watch_ack_flag (stop_watch_ack_flag),
        .set_time_ack_flag   (set_time_ack_flag),
        .set_time_hours      (set_time_hours),
        .set_time_minutes    (set_time_minutes),
        .stop_watch_minutes  (stop_watch_minutes),
        .stop_watch_seconds  (stop_watch_seconds),
        .set_time_en         (set_time_en),
        .set_alarm_en        (set_alarm_en),
        .alarm_sel           (alarm_sel),
        .stop_watch_en       (stop_watch_en),
        .normal_en           (normal_en),
        .alarm_sound         (alarm_sound),
        .alarm_ringing       (alarm_ringing),
        .hours_fsm           (hours_fsm),
        .minutes_fsm         (minutes_fsm)
    );

    always #5 clk = ~clk;

    assign cur = {set_time_en, set_alarm_en, alarm_sel, stop_watch_en, normal_en,
                  alarm_sound, alarm_ringing, hours_fsm, minutes_fsm};

    // Monitor: pop and compare one expectation per falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            total++;
            if (cur !== e) begin
                bad++;
                $display("FAIL %s: got=%h (ste=%b sae=%b sel=%0d swe=%b ne=%b snd=%b ring=%b %0d:%0d) exp=%h (ste=%b sae=%b sel=%0d swe=%b ne=%b snd=%b ring=%b %0d:%0d)",
                         t, cur, cur.ste, cur.sae, cur.sel, cur.swe, cur.ne, cur.snd, cur.ring, cur.hrs, cur.mins,
                         e, e.ste, e.sae, e.sel, e.swe, e.ne, e.snd, e.ring, e.hrs, e.mins);
            end
        end
    end

    function automatic obs_t mk(input int st, input int sel, input bit ne,
                                input logic [1:0] ring, input int h, input int m);
        obs_t o;
        o.ste  = (st == M_T);
        o.sae  = (st == M_A);
        o.sel  = sel[0];
        o.swe  = (st == M_W);
        o.ne   = ne;
        o.snd  = |ring;
        o.ring = ring;
        o.hrs  = h[5:0];
        o.mins = m[5:0];
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue an expectation for the current cycle; returns just after the next rising edge.
    task automatic chk(input string tag, input obs_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
    endtask

    task automatic press_mode();
        mode_button = 1'b1;
        step();
        mode_button = 1'b0;
        step();
    endtask

    task automatic press_inc();
        inc_button = 1'b1;
        step();
        inc_button = 1'b0;
        step();
    endtask

    task automatic press_snooze();
        snooze_button = 1'b1;
        step();
        snooze_button = 1'b0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst = 1'b1;
        sec_tick = 1'b0; mode_button = 1'b0; inc_button = 1'b0; snooze_button = 1'b0;
        normal_hours = 5'd12; normal_minutes = 6'd34;
        alarm_hours = {5'd8, 5'd7}; alarm_minutes = {6'd45, 6'd30};
        alarm_on = 2'b00;
        set_alarm_ack_flag = 1'b1; stop_watch_ack_flag = 1'b1; set_time_ack_flag = 1'b1;
        set_time_hours = 5'd9; set_time_minutes = 6'd10;
        stop_watch_minutes = 6'd5; stop_watch_seconds = 6'd17;
        step(); step();
        chk("reset", mk(M_N, 0, 0, 2'b00, 12, 34));
        rst = 1'b0;
        step();

        // Full mode cycle with acks held high.
        press_mode(); chk("t1_alarm0",    mk(M_A, 0, 0, 2'b00, 7, 30));
        press_mode(); chk("t1_alarm1",    mk(M_A, 1, 0, 2'b00, 8, 45));
        press_mode(); chk("t1_stopwatch", mk(M_W, 0, 0, 2'b00, 5, 17));
        press_mode(); chk("t1_settime",   mk(M_T, 0, 0, 2'b00, 9, 10));
        mode_button = 1'b1; step(); mode_button = 1'b0;
        chk("t1_load_strobe", mk(M_T, 0, 1, 2'b00, 9, 10));
        chk("t1_back_normal", mk(M_N, 0, 0, 2'b00, 12, 34));
        press_mode();
        set_alarm_ack_flag = 1'b0;
        press_mode(); chk("t1_no_ack", mk(M_A, 0, 0, 2'b00, 7, 30));
        set_alarm_ack_flag = 1'b1;
        repeat (4) press_mode();
        chk("t1_cycle_home", mk(M_N, 0, 0, 2'b00, 12, 34));

        // Edge-triggered ring and dismiss.
        alarm_on = 2'b01; normal_hours = 5'd7; normal_minutes = 6'd29;
        step(); chk("t2_before", mk(M_N, 0, 0, 2'b00, 7, 29));
        normal_minutes = 6'd30;
        step(); chk("t2_ring", mk(M_N, 0, 0, 2'b01, 7, 30));
        press_inc(); chk("t2_dismissed", mk(M_N, 0, 0, 2'b00, 7, 30));
        repeat (60) tick();
        chk("t2_no_rering", mk(M_N, 0, 0, 2'b00, 7, 30));

        // Snooze re-ring and ring timeout.
        normal_minutes = 6'd31; step();
        normal_minutes = 6'd30; step();
        chk("t3_ring", mk(M_N, 0, 0, 2'b01, 7, 30));
        press_snooze(); chk("t3_snoozed", mk(M_N, 0, 0, 2'b00, 7, 30));
        tick(); tick(); chk("t3_quiet_2s", mk(M_N, 0, 0, 2'b00, 7, 30));
        tick(); chk("t3_rering", mk(M_N, 0, 0, 2'b01, 7, 30));
        repeat (59) tick(); chk("t3_ring_59s", mk(M_N, 0, 0, 2'b01, 7, 30));
        tick(); chk("t3_ring_timeout", mk(M_N, 0, 0, 2'b00, 7, 30));

        // Priority between coincident channels, and disable while ringing.
        alarm_hours = {5'd6, 5'd6}; alarm_minutes = {6'd0, 6'd0}; alarm_on = 2'b11;
        normal_hours = 5'd5; normal_minutes = 6'd59;
        step(); chk("t4_before", mk(M_N, 0, 0, 2'b00, 5, 59));
        normal_hours = 5'd6; normal_minutes = 6'd0;
        step(); chk("t4_priority", mk(M_N, 0, 0, 2'b01, 6, 0));
        alarm_on = 2'b10;
        step(); chk("t4_disable", mk(M_N, 0, 0, 2'b00, 6, 0));

        // Idle timeout, restart on activity, and timeout beating a mode edge.
        alarm_on = 2'b00; normal_hours = 5'd12; normal_minutes = 6'd34;
        step();
        repeat (3) press_mode(); chk("t5_stopwatch", mk(M_W, 0, 0, 2'b00, 5, 17));
        repeat (29) tick(); chk("t5_29s", mk(M_W, 0, 0, 2'b00, 5, 17));
        press_inc();
        repeat (29) tick(); chk("t5_restarted", mk(M_W, 0, 0, 2'b00, 5, 17));
        sec_tick = 1'b1; chk("t5_timeout_cycle", mk(M_W, 0, 0, 2'b00, 5, 17));
        sec_tick = 1'b0; chk("t5_timeout", mk(M_N, 0, 0, 2'b00, 12, 34));
        repeat (3) press_mode();
        repeat (29) tick();
        mode_button = 1'b1; step(); mode_button = 1'b0;
        sec_tick = 1'b1; chk("t5_mode_vs_timeout_cycle", mk(M_W, 0, 0, 2'b00, 5, 17));
        sec_tick = 1'b0; chk("t5_timeout_wins", mk(M_N, 0, 0, 2'b00, 12, 34));

        // Asynchronous reset with a snooze pending in SET_TIME.
        alarm_hours = {5'd8, 5'd7}; alarm_minutes = {6'd45, 6'd30}; alarm_on = 2'b01;
        normal_hours = 5'd7; normal_minutes = 6'd29; step();
        normal_minutes = 6'd30; step();
        chk("t6_ring", mk(M_N, 0, 0, 2'b01, 7, 30));
        press_snooze();
        repeat (4) press_mode(); chk("t6_settime", mk(M_T, 0, 0, 2'b00, 9, 10));
        rst = 1'b1;
        chk("t6_reset", mk(M_N, 0, 0, 2'b00, 7, 30));
        normal_minutes = 6'd31; step();
        rst = 1'b0; step();
        repeat (5) tick();
        chk("t6_no_snooze", mk(M_N, 0, 0, 2'b00, 7, 31));

        if (total < 12) begin
            bad++;
            $display("FAIL scoreboard: got=%0d comparisons exp>=12", total);
        end
        if (bad != 0) begin
            $display("FAIL summary: got=%0d mismatches exp=0", bad);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
